hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Producer side of the EX-stage operand-select interface: drives forwardA/forwardB and the
//  pipeline hold/bubble controls. Tracks destination tags of in-flight instructions (EX, MEM, WB)
//  in its own tag pipeline. Outputs are registered and aligned with the ID/EX register.
//  Sits beside the ID/EX boundary; consumers are the EX operand muxes, the PC, IF/ID and ID/EX.
// PARAMETERS
//  REG_ADDR_W  5   register-index width
//  PERF_CNT_W  32  width of the perf counters (used only when the macro is defined)
// PORTS
//  clk           in   1           clock, rising edge
//  reset_n       in   1           asynchronous reset, active low
//  id_valid      in   1           ID holds a real instruction
//  id_rs1        in   REG_ADDR_W  ID source 1 index
//  id_rs2        in   REG_ADDR_W  ID source 2 index
//  id_rs1_used   in   1           instruction reads rs1
//  id_rs2_used   in   1           instruction reads rs2
//  id_rd         in   REG_ADDR_W  ID destination index
//  id_reg_wen    in   1           instruction writes rd
//  id_mem_read   in   1           instruction is a load
//  ex_flush      in   1           taken branch/jump resolved in EX; kill IF/ID and ID contents
//  forwardA      out  2           EX operand-A select: 00 regfile, 01 WB_data, 10 EX_MEM_alu_out
//  forwardB      out  2           EX operand-B select, same encoding
//  pc_write      out  1           0 = hold PC
//  if_id_write   out  1           0 = hold IF/ID
//  id_ex_bubble  out  1           1 = load NOP into ID/EX
// BEHAVIOUR
//  - Reset (async, reset_n=0): all tag-stage valids 0; forwardA=forwardB=00; pc_write=1;
//    if_id_write=1; id_ex_bubble=0. Reset mid-stall abandons the stall.
//  - Tag pipe stages EX, MEM, WB, each holding {valid, rd, wen, mem_read}. It advances every cycle.
//    EX <- ID tags when the instruction advances. EX <- invalid when a bubble or flush is inserted.
//  - Match rule: src matches stage S iff used && S.valid && S.wen && S.rd==src && src!=0.
//  - Load-use stall (combinational): id_valid && operand matches EX stage with EX.mem_read.
//    Effect: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle.
//  - Forward select, registered on the edge where ID enters EX:
//    - match current EX (non-load) -> 10;
//    - else match current MEM -> 01;
//    - else 00.
//    EX beats MEM (youngest wins).
//  - After a load-use stall the load sits in MEM, so the dependent op gets 01. It never gets 10 from a load.
//  - Bubble or flush cycle: forwardA/forwardB registered as 00.
//  - ex_flush: id_ex_bubble=1, pc_write=1, if_id_write=1.
//    Flush outranks load-use stall when both are true in the same cycle.
//  - A WB writer whose reader is in ID is not forwarded. The register file is write-before-read.
//  - id_valid=0: no stall is raised and EX receives an invalid tag.
//  - Latency: stall is same-cycle. Forward selects are valid 1 cycle after ID, for the whole EX cycle.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    - adds output perf_stall_cnt [PERF_CNT_W], +1 per load-use stall cycle;
//    - adds output perf_flush_cnt [PERF_CNT_W], +1 per ex_flush cycle;
//    - both saturate at all-ones and reset to 0.
//  Undefined: both ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - risc_v_defines.vh gets: FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the tag-stage field widths.
//  - One sub-module, fwd_select: given src, used, EX tag and MEM tag, it returns the 2-bit select.
//    Instantiate it twice (A and B).
//  - Stall and flush logic plus the tag pipeline stay in the top module.
// TESTING
//  1. ID add x5 <- x1,x2 (nothing in flight) -> forwardA=forwardB=00, no stall.
//  2. add x3 then sub x4 <- x3,x3 back-to-back -> sub in EX sees forwardA=forwardB=10.
//  3. add x3, nop, or x6 <- x7,x3 -> forwardA=00, forwardB=01.
//  4. add x3 and lw x3 both precede and x9 <- x3 -> forward 10 from the younger one only.
//  5. lw x8 then add x2 <- x8,x1 ->
//     - 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1;
//     - then add in EX with forwardA=01.
//  6. Mixed cases:
//     - rd=x0 writer then reader of x0 -> forward 00;
//     - ex_flush together with a load-use condition -> bubble, pc_write=1;
//     - reset_n low during a stall -> all outputs at reset values;
//     - macro build: perf counters match the stall and flush counts.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared encodings for the hazard/forwarding block: operand-select codes and EX-stage tag flags.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hazard_fwd_unit_pkg;

    // EX operand-mux select encoding
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    // Per-stage tag flags carried beside the destination index
    typedef struct packed {
        logic valid;
        logic wen;
        logic mem_read;
    } tag_flags_t;

endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Per-operand forward select: picks EX result, MEM/WB result or register file for one source.
// Latency: combinational.
// Backpressure: none; a matching load in EX is left to the stall logic and selects nothing here.
module fwd_select
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  used,
    input  tag_flags_t            ex_flags,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_valid,
    input  logic                  mem_wen,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output logic [1:0]            sel
);

    logic src_live;
    logic ex_hit;
    logic mem_hit;

    // x0 is hard-wired zero and never forwarded
    assign src_live = used && (src != '0);
    assign ex_hit   = src_live && ex_flags.valid && ex_flags.wen && !ex_flags.mem_read && (ex_rd == src);
    assign mem_hit  = src_live && mem_valid && mem_wen && (mem_rd == src);

    // Youngest producer wins: EX before MEM
    always_comb begin
        sel = FWD_REGFILE;
        if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forward-select generation beside ID/EX; HAZARD_PERF_CNT_EN adds stall/flush counters.
// Latency: stall/bubble controls combinational in the ID cycle; forward selects registered, valid for the EX cycle.
// Backpressure: load-use holds PC and IF/ID for one cycle and bubbles ID/EX; ex_flush bubbles without holding.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_wen,
    input  logic                  id_mem_read,
    input  logic                  ex_flush,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);

    if (REG_ADDR_W < 1 || PERF_CNT_W < 1) begin : g_param_check
        $error("hazard_fwd_unit: REG_ADDR_W and PERF_CNT_W must be positive");
    end

    // WB is not tracked: the register file is write-before-read, so a WB writer never needs forwarding.
    tag_flags_t            ex_flags;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_valid;
    logic                  mem_wen;
    logic [REG_ADDR_W-1:0] mem_rd;

    logic       rs1_load_hit;
    logic       rs2_load_hit;
    logic       load_use;
    logic       stall;
    logic       advance;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    assign rs1_load_hit = id_rs1_used && (id_rs1 != '0) && ex_flags.valid && ex_flags.wen
                          && ex_flags.mem_read && (ex_rd == id_rs1);
    assign rs2_load_hit = id_rs2_used && (id_rs2 != '0) && ex_flags.valid && ex_flags.wen
                          && ex_flags.mem_read && (ex_rd == id_rs2);
    assign load_use     = id_valid && (rs1_load_hit || rs2_load_hit);

    // Flush kills the ID instruction, so a coincident load-use stall is moot
    assign stall        = load_use && !ex_flush;
    assign advance      = id_valid && !stall && !ex_flush;

    assign pc_write     = !stall;
    assign if_id_write  = !stall;
    assign id_ex_bubble = stall || ex_flush;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src       (id_rs1),
        .used      (id_rs1_used),
        .ex_flags  (ex_flags),
        .ex_rd     (ex_rd),
        .mem_valid (mem_valid),
        .mem_wen   (mem_wen),
        .mem_rd    (mem_rd),
        .sel       (sel_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src       (id_rs2),
        .used      (id_rs2_used),
        .ex_flags  (ex_flags),
        .ex_rd     (ex_rd),
        .mem_valid (mem_valid),
        .mem_wen   (mem_wen),
        .mem_rd    (mem_rd),
        .sel       (sel_b)
    );

    // Tag pipeline: EX takes the ID tags only when the instruction really advances, MEM follows EX
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_flags  <= '0;
            ex_rd     <= '0;
            mem_valid <= 1'b0;
            mem_wen   <= 1'b0;
            mem_rd    <= '0;
        end else begin
            if (advance) begin
                ex_flags.valid    <= 1'b1;
                ex_flags.wen      <= id_reg_wen;
                ex_flags.mem_read <= id_mem_read;
                ex_rd             <= id_rd;
            end else begin
                ex_flags <= '0;
                ex_rd    <= '0;
            end
            mem_valid <= ex_flags.valid;
            mem_wen   <= ex_flags.wen;
            mem_rd    <= ex_rd;
        end
    end

    // Forward selects captured as ID enters EX; bubbles and empty slots select the register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            forwardA <= FWD_REGFILE;
            forwardB <= FWD_REGFILE;
        end else if (advance) begin
            forwardA <= sel_a;
            forwardB <= sel_b;
        end else begin
            forwardA <= FWD_REGFILE;
            forwardB <= FWD_REGFILE;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [PERF_CNT_W-1:0] PERF_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

    // Saturating event counters for load-use stall cycles and flush cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_ONE;
            end
            if (ex_flush && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + PERF_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_wen;
    logic       id_mem_read;
    logic       ex_flush;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_bubble;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    hazard_fwd_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_wen   (id_reg_wen),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .forwardA     (forwardA),
        .forwardB     (forwardB),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_bubble (id_ex_bubble)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-flight instructions, youngest first (index 0 = EX, 1 = MEM)
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       wen;
        bit       mr;
    } minst_t;

    minst_t pipe[$];
    int     checks = 0;
    int     passed = 0;
    int     n_stall = 0;
    int     n_flush = 0;
    bit [1:0] exp_fa = 2'b00;
    bit [1:0] exp_fb = 2'b00;
    bit     obs_pc, obs_ifid, obs_bub;
    bit     stalled;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit writes(input int idx, input bit [4:0] src, input bit used);
        return used && src != 0 && pipe[idx].valid && pipe[idx].wen && pipe[idx].rd == src;
    endfunction

    // Youngest in-flight producer decides the source of the operand
    function automatic bit [1:0] prod_sel(input bit [4:0] src, input bit used);
        if (writes(0, src, used)) return 2'b10;
        if (writes(1, src, used)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit load_hit(input bit [4:0] src, input bit used);
        return writes(0, src, used) && pipe[0].mr;
    endfunction

    task automatic model_reset();
        minst_t z;
        z = '{valid: 1'b0, rd: 5'd0, wen: 1'b0, mr: 1'b0};
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        exp_fa = 2'b00;
        exp_fb = 2'b00;
        n_stall = 0;
        n_flush = 0;
    endtask

    // One ID cycle: drive, check same-cycle controls and current EX selects, then clock the model
    task automatic step(input bit v, input bit [4:0] rs1, input bit [4:0] rs2, input bit u1,
                        input bit u2, input bit [4:0] rd, input bit wen, input bit mr,
                        input bit fl, output bit st);
        bit ld, adv;
        minst_t nw;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_reg_wen = wen; id_mem_read = mr; ex_flush = fl;
        #3;
        ld = v && (load_hit(rs1, u1) || load_hit(rs2, u2));
        st = ld && !fl;
        obs_pc = pc_write; obs_ifid = if_id_write; obs_bub = id_ex_bubble;
        chk("pc_write", 32'(pc_write), 32'(!st));
        chk("if_id_write", 32'(if_id_write), 32'(!st));
        chk("id_ex_bubble", 32'(id_ex_bubble), 32'(st || fl));
        chk("forwardA", 32'(forwardA), 32'(exp_fa));
        chk("forwardB", 32'(forwardB), 32'(exp_fb));
        if (st) n_stall++;
        if (fl) n_flush++;
        adv = v && !st && !fl;
        exp_fa = adv ? prod_sel(rs1, u1) : 2'b00;
        exp_fb = adv ? prod_sel(rs2, u2) : 2'b00;
        nw = '{valid: adv, rd: adv ? rd : 5'd0, wen: adv && wen, mr: adv && mr};
        pipe.push_front(nw);
        void'(pipe.pop_back());
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        bit s;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, s);
    endtask

    task automatic alu(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        bit s;
        step(1, rs1, rs2, 1, 1, rd, 1, 0, 0, s);
    endtask

    task automatic load(input bit [4:0] rd, input bit [4:0] rs1);
        bit s;
        step(1, rs1, 0, 1, 0, rd, 1, 1, 0, s);
    endtask

    task automatic drain();
        repeat (3) nop();
    endtask

    initial begin
        bit v, u1, u2, wen, mr, fl;
        bit [4:0] rs1, rs2, rd;

        reset_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_reg_wen = 0; id_mem_read = 0; ex_flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_forwardA", 32'(forwardA), 32'd0);
        chk("rst_forwardB", 32'(forwardB), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_if_id_write", 32'(if_id_write), 32'd1);
        chk("rst_bubble", 32'(id_ex_bubble), 32'd0);
        reset_n = 1'b1;

        // 1: nothing in flight
        alu(5, 1, 2);
        chk("t1_fwdA", 32'(forwardA), 32'd0);
        chk("t1_fwdB", 32'(forwardB), 32'd0);
        drain();

        // 2: back-to-back dependency on EX
        alu(3, 1, 2);
        alu(4, 3, 3);
        chk("t2_fwdA", 32'(forwardA), 32'd2);
        chk("t2_fwdB", 32'(forwardB), 32'd2);
        drain();

        // 3: one instruction gap -> from MEM
        alu(3, 1, 2);
        nop();
        alu(6, 7, 3);
        chk("t3_fwdA", 32'(forwardA), 32'd0);
        chk("t3_fwdB", 32'(forwardB), 32'd1);
        drain();

        // 4: two producers of x3, younger one wins
        load(3, 1);
        alu(3, 1, 2);
        alu(9, 3, 0);
        chk("t4_fwdA", 32'(forwardA), 32'd2);
        chk("t4_fwdB", 32'(forwardB), 32'd0);
        drain();

        // 5: load-use stall for one cycle, then forward from MEM
        load(8, 1);
        alu(2, 8, 1);
        chk("t5_stall_pc", 32'(obs_pc), 32'd0);
        chk("t5_stall_ifid", 32'(obs_ifid), 32'd0);
        chk("t5_stall_bub", 32'(obs_bub), 32'd1);
        alu(2, 8, 1);
        chk("t5_no_restall", 32'(obs_pc), 32'd1);
        chk("t5_fwdA", 32'(forwardA), 32'd1);
        drain();

        // 6a: x0 is never forwarded
        alu(0, 1, 2);
        alu(7, 0, 0);
        chk("t6a_fwdA", 32'(forwardA), 32'd0);
        drain();

        // 6b: flush together with load-use
        load(8, 1);
        step(1, 8, 1, 1, 1, 2, 1, 0, 1, stalled);
        chk("t6b_bub", 32'(obs_bub), 32'd1);
        chk("t6b_pc", 32'(obs_pc), 32'd1);
        chk("t6b_fwdA", 32'(forwardA), 32'd0);
        drain();

        // 6c: reset during a stall
        load(8, 1);
        id_valid = 1; id_rs1 = 8; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 0;
        id_rd = 2; id_reg_wen = 1; id_mem_read = 0; ex_flush = 0;
        #2;
        chk("t6c_pre_pc", 32'(pc_write), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("t6c_pc", 32'(pc_write), 32'd1);
        chk("t6c_ifid", 32'(if_id_write), 32'd1);
        chk("t6c_bub", 32'(id_ex_bubble), 32'd0);
        chk("t6c_fwdA", 32'(forwardA), 32'd0);
        chk("t6c_fwdB", 32'(forwardB), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("t6c_perf_stall", perf_stall_cnt, 32'd0);
        chk("t6c_perf_flush", perf_flush_cnt, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        id_valid = 0; id_rs1_used = 0;

        // Random traffic on a small register set to provoke hazards
        stalled = 0;
        v = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; wen = 0; mr = 0;
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                v   = ($urandom_range(0, 7) != 0);
                rs1 = 5'($urandom_range(0, 5));
                rs2 = 5'($urandom_range(0, 5));
                u1  = ($urandom_range(0, 5) != 0);
                u2  = ($urandom_range(0, 2) != 0);
                rd  = 5'($urandom_range(0, 5));
                wen = ($urandom_range(0, 5) != 0);
                mr  = ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 11) == 0);
            step(v, rs1, rs2, u1, u2, rd, wen, mr, fl, stalled);
        end

`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'(n_stall));
        chk("perf_flush_cnt", perf_flush_cnt, 32'(n_flush));
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
